fb_double_buffer: RTL and testbench

- Double-buffered 1-bit framebuffer between the GPU pixel-write stage (upstream) and the video scanout/timing stage (downstream).
- The GPU writes only the back bank; scanout reads only the front bank.
- Banks swap on request, only during vertical blanking. The new back bank is optionally auto-cleared so the next frame starts black.

---
 rtl/fb_double_buffer.sv | 160 ++++++++++++++++
 tb/tb_fb_double_buffer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_double_buffer.sv
// fb_double_buffer
// Double-buffered 1-bit framebuffer. The GPU pixel-write stage only writes
// the back bank. Scanout only reads the front bank. A swap request is held
// pending until vertical blanking, then the banks exchange roles. The new
// back bank is optionally auto-cleared so the next frame starts from
// CLEAR_COLOR.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   ce              clock enable for all non-reset state
//   wr_en/addr/data GPU write into the back bank (pixel index y*HOR+x)
//   rd_en/addr      scanout read of the front bank
//   rd_data         front-bank pixel, valid one cycle after rd_en
//   vblank          vertical blanking from the timing generator
//   swap_req        pulse: frame complete, swap at the next vblank
//   clear_req       pulse: clear the back bank now
//   front_sel       bank currently scanned out
//   busy            clearing or swap pending; upstream must hold off writes
//   swap_done       one-cycle pulse on the swap cycle
module fb_double_buffer #(
  parameter int unsigned HOR_ACTIVE_PIXELS = 640,
  parameter int unsigned VER_ACTIVE_PIXELS = 480,
  parameter bit          AUTO_CLEAR        = 1'b1,
  parameter bit          CLEAR_COLOR       = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        wr_en,
  input  logic [20:0] wr_addr,
  input  logic        wr_data,
  input  logic        rd_en,
  input  logic [20:0] rd_addr,
  output logic        rd_data,
  input  logic        vblank,
  input  logic        swap_req,
  input  logic        clear_req,
  output logic        front_sel,
  output logic        busy,
  output logic        swap_done
);

  localparam int unsigned N      = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
  localparam int unsigned AW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [20:0] N_W    = 21'(N);
  localparam logic [20:0] LAST_W = 21'(N - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_front_sel;
  logic        r_swap_pending;
  logic [20:0] r_clr_cnt;
  logic        r_rd_data;
  logic        r_swap_done;

  logic        r_bank0 [0:N-1];
  logic        r_bank1 [0:N-1];

  logic          w_we;
  logic [AW-1:0] w_wr_idx;
  logic          w_wr_bit;
  logic [AW-1:0] w_rd_idx;

  // Single write port into the back bank: the clear sweep owns it while in
  // CLEAR, so GPU writes issued then are simply dropped.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_we     = 1'b0;
    w_wr_idx = '0;
    w_wr_bit = 1'b0;
    if (rst && ce) begin
      if (r_state == S_CLEAR) begin
        w_we     = 1'b1;
        w_wr_idx = r_clr_cnt[AW-1:0];
        w_wr_bit = CLEAR_COLOR;
      end else if (wr_en && (wr_addr < N_W)) begin
        w_we     = 1'b1;
        w_wr_idx = wr_addr[AW-1:0];
        w_wr_bit = wr_data;
      end
    end
  end

  assign w_rd_idx = rd_addr[AW-1:0];

  // Back bank is the one not selected for scanout.
  // NOTE: the pixel arrays carry no reset so they map onto block RAM; their
  // contents after reset are whatever the last frame left behind.
  always_ff @(posedge clk) begin
    if (w_we && r_front_sel)  r_bank0[w_wr_idx] <= w_wr_bit;
    if (w_we && !r_front_sel) r_bank1[w_wr_idx] <= w_wr_bit;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the pre-edge value (the read in the swap cycle
  // therefore still uses the old front bank).
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_front_sel    <= 1'b0;
      r_swap_pending <= 1'b0;
      r_clr_cnt      <= '0;
      r_rd_data      <= 1'b0;
      r_swap_done    <= 1'b0;
    end else if (ce) begin
      if (rd_en) begin
        if (rd_addr < N_W)
          r_rd_data <= r_front_sel ? r_bank1[w_rd_idx] : r_bank0[w_rd_idx];
        else
          r_rd_data <= 1'b0;
      end

      r_swap_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (r_swap_pending && vblank) begin
            // A swap_req or clear_req arriving on the swap cycle is absorbed.
            r_front_sel    <= ~r_front_sel;
            r_swap_done    <= 1'b1;
            r_swap_pending <= 1'b0;
            if (AUTO_CLEAR) begin
              r_state   <= S_CLEAR;
              r_clr_cnt <= '0;
            end
          end else begin
            if (swap_req) r_swap_pending <= 1'b1;
            if (clear_req) begin
              r_state   <= S_CLEAR;
              r_clr_cnt <= '0;
            end
          end
        end

        S_CLEAR: begin
          // Swaps wait for IDLE; clear_req cannot restart the sweep.
          if (swap_req) r_swap_pending <= 1'b1;
          if (r_clr_cnt == LAST_W) begin
            r_clr_cnt <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_clr_cnt <= r_clr_cnt + 21'd1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_data   = r_rd_data;
  assign front_sel = r_front_sel;
  assign swap_done = r_swap_done;
  assign busy      = (r_state == S_CLEAR) | r_swap_pending;

endmodule

// File: tb/tb_fb_double_buffer.sv
// Testbench for fb_double_buffer (8x4 frame, 32 pixels per bank).
// Two instances share all inputs: one with auto-clear, one without.
// A behavioural model predicts every cycle's outputs; the expectation is
// queued at the clock edge and a separate monitor compares it on the
// following falling edge. Directed sequences add explicit checks on top.
module tb_fb_double_buffer;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst, ce, wr_en, wr_data, rd_en, vblank, swap_req, clear_req;
  logic [20:0] wr_addr, rd_addr;

  logic rd_ac, front_ac, busy_ac, sd_ac;
  logic rd_nc, front_nc, busy_nc, sd_nc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fb_double_buffer #(
    .HOR_ACTIVE_PIXELS(8), .VER_ACTIVE_PIXELS(4),
    .AUTO_CLEAR(1'b1), .CLEAR_COLOR(1'b0)
  ) dut_ac (
    .clk(clk), .rst(rst), .ce(ce),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_ac),
    .vblank(vblank), .swap_req(swap_req), .clear_req(clear_req),
    .front_sel(front_ac), .busy(busy_ac), .swap_done(sd_ac)
  );

  fb_double_buffer #(
    .HOR_ACTIVE_PIXELS(8), .VER_ACTIVE_PIXELS(4),
    .AUTO_CLEAR(1'b0), .CLEAR_COLOR(1'b0)
  ) dut_nc (
    .clk(clk), .rst(rst), .ce(ce),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_nc),
    .vblank(vblank), .swap_req(swap_req), .clear_req(clear_req),
    .front_sel(front_nc), .busy(busy_nc), .swap_done(sd_nc)
  );

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance: two banks of pixels, which bank is shown, whether a swap
  // is owed, and how many clear writes are still outstanding.
  typedef struct packed {
    logic rd;
    logic front;
    logic busy;
    logic sd;
  } exp_t;

  bit   auto_clr [2] = '{1'b1, 1'b0};
  logic m_bank   [2][2][N];
  bit   m_front  [2];
  bit   m_pend   [2];
  int   m_left   [2];
  logic m_rd     [2];
  bit   m_sd     [2];

  exp_t q_ac[$];
  exp_t q_nc[$];

  initial begin
    for (int k = 0; k < 2; k++)
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < N; i++) m_bank[k][b][i] = 1'bx;
  end

  task automatic model_step(input int k);
    bit f;
    if (!rst) begin
      m_front[k] = 1'b0; m_pend[k] = 1'b0; m_left[k] = 0;
      m_rd[k] = 1'b0; m_sd[k] = 1'b0;
    end else if (ce) begin
      f = m_front[k];
      if (rd_en) m_rd[k] = (rd_addr < N) ? m_bank[k][f][rd_addr] : 1'b0;
      m_sd[k] = 1'b0;
      if (m_left[k] > 0) begin
        m_bank[k][!f][N - m_left[k]] = 1'b0;
        m_left[k]--;
        if (swap_req) m_pend[k] = 1'b1;
      end else begin
        if (wr_en && wr_addr < N) m_bank[k][!f][wr_addr] = wr_data;
        if (m_pend[k] && vblank) begin
          m_front[k] = !f; m_sd[k] = 1'b1; m_pend[k] = 1'b0;
          if (auto_clr[k]) m_left[k] = N;
        end else begin
          if (swap_req)  m_pend[k] = 1'b1;
          if (clear_req) m_left[k] = N;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
    q_ac.push_back('{m_rd[0], m_front[0], m_pend[0] || m_left[0] > 0, m_sd[0]});
    q_nc.push_back('{m_rd[1], m_front[1], m_pend[1] || m_left[1] > 0, m_sd[1]});
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (q_ac.size() > 0) begin
      e = q_ac.pop_front();
      check("ac_rd_data",   rd_ac,    e.rd);
      check("ac_front_sel", front_ac, e.front);
      check("ac_busy",      busy_ac,  e.busy);
      check("ac_swap_done", sd_ac,    e.sd);
    end
    if (q_nc.size() > 0) begin
      e = q_nc.pop_front();
      check("nc_rd_data",   rd_nc,    e.rd);
      check("nc_front_sel", front_nc, e.front);
      check("nc_busy",      busy_nc,  e.busy);
      check("nc_swap_done", sd_nc,    e.sd);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int a, input logic d);
    wr_en = 1'b1; wr_addr = 21'(a); wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic rd(input int a);
    rd_en = 1'b1; rd_addr = 21'(a);
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
  endtask

  task automatic fill(input logic v);
    for (int i = 0; i < N; i++) wr(i, v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t;
    logic prev;

    rst = 1'b0; ce = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = 1'b0;
    rd_en = 1'b0; rd_addr = '0; vblank = 1'b0; swap_req = 1'b0; clear_req = 1'b0;

    // Give both banks of both instances defined contents.
    cyc(2); rst = 1'b1;
    fill(1'b0);
    vblank = 1'b1; pulse_swap(); cyc(); vblank = 1'b0;
    cyc(34);
    fill(1'b0);

    // 1. Reset, write, swap, read back.
    rst = 1'b0; cyc(2);
    check("t1_reset_front", front_ac, 1'b0);
    check("t1_reset_busy",  busy_ac,  1'b0);
    check("t1_reset_rd",    rd_ac,    1'b0);
    rst = 1'b1;
    wr(5, 1'b1);
    vblank = 1'b1; pulse_swap(); cyc(); vblank = 1'b0;
    check("t1_front_sel", front_ac, 1'b1);
    check("t1_swap_done", sd_ac,    1'b1);
    cyc();
    check("t1_swap_done_once", sd_ac, 1'b0);
    rd(5);
    check("t1_rd_ac", rd_ac, 1'b1);
    check("t1_rd_nc", rd_nc, 1'b1);
    cyc(34);

    // 2. Swap held off until vblank.
    pulse_swap();
    for (int i = 0; i < 10; i++) begin
      check("t2_busy_wait",  busy_ac,  1'b1);
      check("t2_front_hold", front_ac, 1'b1);
      cyc();
    end
    vblank = 1'b1; cyc(); vblank = 1'b0;
    check("t2_front_toggle", front_ac, 1'b0);
    check("t2_swap_done",    sd_ac,    1'b1);
    cyc(34);

    // 3. Auto-clear length and cleared contents.
    fill(1'b1);
    vblank = 1'b1; pulse_swap(); cyc(); vblank = 1'b0;
    check("t3_swap_done", sd_ac, 1'b1);
    n = 0;
    while (busy_ac === 1'b1 && n < 60) begin cyc(); n++; end
    check_int("t3_clear_cycles", n, 32);
    vblank = 1'b1; pulse_swap(); cyc(); vblank = 1'b0;
    for (int i = 0; i < N; i++) begin
      rd(i);
      check("t3_cleared_rd", rd_ac, 1'b0);
    end
    cyc(34);

    // 4. Write during CLEAR dropped; out-of-range write and read.
    clear_req = 1'b1; cyc(); clear_req = 1'b0;
    cyc(20);
    wr(3, 1'b1);
    cyc(20);
    wr(40, 1'b1);
    vblank = 1'b1; pulse_swap(); cyc(); vblank = 1'b0;
    rd(3);
    check("t4_dropped_wr", rd_ac, 1'b0);
    rd(40);
    check("t4_rd_oob", rd_ac, 1'b0);
    cyc(34);

    // 5a. clear_req on the swap cycle is dropped without auto-clear.
    vblank = 1'b1; swap_req = 1'b1; cyc(); swap_req = 1'b0;
    clear_req = 1'b1; cyc(); clear_req = 1'b0; vblank = 1'b0;
    check("t5_swap_done_nc", sd_nc,   1'b1);
    check("t5_no_clear_nc",  busy_nc, 1'b0);
    cyc();
    check("t5_still_idle_nc", busy_nc, 1'b0);
    cyc(34);

    // 5b. Two swap requests before vblank give one toggle.
    pulse_swap(); cyc(3); pulse_swap(); cyc(3);
    vblank = 1'b1;
    t = 0; prev = front_nc;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (front_nc !== prev) t++;
      prev = front_nc;
    end
    vblank = 1'b0;
    check_int("t5_one_toggle", t, 1);
    cyc(34);

    // 6a. Reset part-way through CLEAR.
    clear_req = 1'b1; cyc(); clear_req = 1'b0;
    cyc(10);
    rst = 1'b0; cyc(); rst = 1'b1;
    check("t6_rst_busy",  busy_ac,  1'b0);
    check("t6_rst_front", front_ac, 1'b0);
    check("t6_rst_busy_nc", busy_nc, 1'b0);

    // 6b. ce low for 5 cycles stretches CLEAR to 37 cycles.
    clear_req = 1'b1; cyc(); clear_req = 1'b0;
    n = 0;
    while (busy_ac === 1'b1 && n < 60) begin
      ce = (n >= 10 && n < 15) ? 1'b0 : 1'b1;
      cyc(); n++;
    end
    ce = 1'b1;
    check_int("t6_ce_clear_cycles", n, 37);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 499) != 0);
      ce        = ($urandom_range(0, 9) != 0);
      wr_en     = $urandom_range(0, 1);
      wr_addr   = 21'($urandom_range(0, 39));
      wr_data   = $urandom_range(0, 1);
      rd_en     = $urandom_range(0, 1);
      rd_addr   = 21'($urandom_range(0, 39));
      if ($urandom_range(0, 19) == 0) vblank = ~vblank;
      swap_req  = ($urandom_range(0, 24) == 0);
      clear_req = ($urandom_range(0, 39) == 0);
      cyc();
    end
    rst = 1'b1; ce = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    swap_req = 1'b0; clear_req = 1'b0;
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
